// File: rtl/l2_adaptor_pkg.sv
// Shared definitions for the L2 cacheline adaptor: FSM state encoding,
// default widths and the derived beat count / line offset.
package l2_adaptor_pkg;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_BURST_W = 64;
  localparam int DEF_ADDR_W  = 32;

  // Beats per line and the number of byte-offset address bits in a line.
  localparam int BEATS  = DEF_LINE_W / DEF_BURST_W;
  localparam int OFFSET = $clog2(DEF_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// L2 cacheline adaptor: turns one 256-bit line read/write request from the L2
// into a burst of 64-bit beats on the pmem port and returns a one-cycle
// completion pulse. Writes win over reads when both are requested.
// Optional build macro: L2_ADAPTOR_PERF_EN adds internal burst/stall counters
// (rd_burst_count, wr_burst_count, stall_cycle_count) readable hierarchically.
module l2_cacheline_adaptor
  import l2_adaptor_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cacheline_read,
  input  logic               cacheline_write,
  input  logic [ADDR_W-1:0]  cacheline_address,
  input  logic [LINE_W-1:0]  cacheline_wdata,
  output logic [LINE_W-1:0]  cacheline_rdata,
  output logic               cacheline_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
  // Clears the byte-within-line bits so the burst starts on a line boundary.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((LINE_W / 8) - 1));

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] rd_buf;
  logic [LINE_W-1:0] wr_buf;
  logic              last_beat;

  assign last_beat       = pmem_resp && (cnt == LAST_BEAT);
  assign cacheline_rdata = rd_buf;
  assign pmem_wdata      = wr_buf[int'(cnt)*BURST_W +: BURST_W];

  // Request FSM: latches the request, walks the beats, pulses the completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rd_buf         <= '0;
      wr_buf         <= '0;
      pmem_address   <= '0;
      pmem_read      <= 1'b0;
      pmem_write     <= 1'b0;
      cacheline_resp <= 1'b0;
    end else begin
      cacheline_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (cacheline_write) begin
            wr_buf       <= cacheline_wdata;
            pmem_address <= cacheline_address & ALIGN_MASK;
            pmem_write   <= 1'b1;
            state        <= WR_BURST;
          end else if (cacheline_read) begin
            pmem_address <= cacheline_address & ALIGN_MASK;
            pmem_read    <= 1'b1;
            state        <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (pmem_resp) begin
            rd_buf[int'(cnt)*BURST_W +: BURST_W] <= pmem_rdata;
            if (last_beat) begin
              cnt            <= '0;
              pmem_read      <= 1'b0;
              cacheline_resp <= 1'b1;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (pmem_resp) begin
            if (last_beat) begin
              cnt            <= '0;
              pmem_write     <= 1'b0;
              cacheline_resp <= 1'b1;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_ADAPTOR_PERF_EN
  logic [31:0] rd_burst_count;
  logic [31:0] wr_burst_count;
  logic [31:0] stall_cycle_count;

  // Performance tallies: completed bursts per direction and stalled burst cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_burst_count    <= '0;
      wr_burst_count    <= '0;
      stall_cycle_count <= '0;
    end else begin
      if (state == RD_BURST && last_beat) rd_burst_count <= rd_burst_count + 32'd1;
      if (state == WR_BURST && last_beat) wr_burst_count <= wr_burst_count + 32'd1;
      if ((state == RD_BURST || state == WR_BURST) && !pmem_resp)
        stall_cycle_count <= stall_cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Testbench for l2_cacheline_adaptor: table of directed line transfers, a
// hand-written mid-burst reset sequence and randomized transfers, all checked
// cycle by cycle against a transaction-level model of the pmem burst.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         cacheline_read;
  logic         cacheline_write;
  logic [31:0]  cacheline_address;
  logic [255:0] cacheline_wdata;
  logic [255:0] cacheline_rdata;
  logic         cacheline_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;
  int rd_tally = 0;
  int wr_tally = 0;
  int stall_tally = 0;

  always #5 clk = ~clk;

  l2_cacheline_adaptor dut (
    .clk               (clk),
    .rst               (rst),
    .cacheline_read    (cacheline_read),
    .cacheline_write   (cacheline_write),
    .cacheline_address (cacheline_address),
    .cacheline_wdata   (cacheline_wdata),
    .cacheline_rdata   (cacheline_rdata),
    .cacheline_resp    (cacheline_resp),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

  typedef struct {
    logic             wr;
    logic             rd;
    logic [31:0]      addr;
    logic [3:0][63:0] wbeats;
    logic [3:0][63:0] rbeats;
    logic [255:0]     exp_rdata;
    logic [31:0]      exp_addr;
    int               stall;   // 0: none, N>0: resp every Nth cycle, <0: random
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One line transfer as seen by the L2 plus a pmem responder. Called at
  // posedge+1; returns at posedge+1 of the idle cycle after completion with
  // the request already dropped.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [3:0][63:0] wb, input logic [3:0][63:0] rb,
                         input logic [255:0] exp_rd, input logic [31:0] exp_addr,
                         input int stall, input string nm);
    int k;
    int c;
    int done_cyc;
    bit done;
    bit in_burst;
    bit exp_resp;
    k = 0; c = 0; done_cyc = -10; done = 0;
    cacheline_write   = wr;
    cacheline_read    = rd;
    cacheline_address = addr;
    cacheline_wdata   = wb;
    pmem_resp  = 1'($urandom % 2);
    pmem_rdata = {$urandom, $urandom};
    while (!done && c < 400) begin
      @(negedge clk);
      in_burst = (c >= 1) && (k < 4);
      exp_resp = (c == done_cyc + 1);
      chk({nm, " pmem_read"},  256'(pmem_read),  256'(in_burst && !wr));
      chk({nm, " pmem_write"}, 256'(pmem_write), 256'(in_burst && wr));
      chk({nm, " resp"},       256'(cacheline_resp), 256'(exp_resp));
      if (in_burst) begin
        chk({nm, " pmem_address"}, 256'(pmem_address), 256'(exp_addr));
        if (wr) chk({nm, " pmem_wdata"}, 256'(pmem_wdata), 256'(wb[k]));
      end
      if (exp_resp) begin
        if (!wr) chk({nm, " rdata"}, cacheline_rdata, exp_rd);
        if (wr) wr_tally++; else rd_tally++;
        done = 1;
      end
      if (in_burst) begin
        if (pmem_resp) begin
          k++;
          if (k == 4) done_cyc = c;
        end else begin
          stall_tally++;
        end
      end
      @(posedge clk); #1;
      c++;
      if (done) begin
        cacheline_read  = 1'b0;
        cacheline_write = 1'b0;
      end
      if (!done && k < 4) begin
        if (stall == 0)      pmem_resp = 1'b1;
        else if (stall < 0)  pmem_resp = 1'($urandom % 2);
        else                 pmem_resp = ((c % stall) == 0);
        pmem_rdata = rb[k];
      end else begin
        pmem_resp  = 1'($urandom % 2);
        pmem_rdata = {$urandom, $urandom};
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: got no resp expected resp within 400 cycles", nm);
      cacheline_read  = 1'b0;
      cacheline_write = 1'b0;
    end
  endtask

  initial begin
    logic [3:0][63:0] rb;
    logic [3:0][63:0] wb;
    logic [63:0]      q[$];
    logic [31:0]      a;
    logic             wr;
    logic             rd;
    int               sel;

    tbl[0] = '{wr:1'b0, rd:1'b1, addr:32'h0000_1040, wbeats:'0,
               rbeats:{64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
               exp_rdata:256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
               exp_addr:32'h0000_1040, stall:0};
    tbl[1] = '{wr:1'b1, rd:1'b0, addr:32'h0000_2000,
               wbeats:{64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A},
               rbeats:'0, exp_rdata:'0, exp_addr:32'h0000_2000, stall:3};
    tbl[2] = '{wr:1'b0, rd:1'b1, addr:32'h1234_567C, wbeats:'0,
               rbeats:{64'hDEADBEEF00000003, 64'hDEADBEEF00000002, 64'hDEADBEEF00000001, 64'hDEADBEEF00000000},
               exp_rdata:256'hDEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001_DEADBEEF00000000,
               exp_addr:32'h1234_5660, stall:2};
    tbl[3] = '{wr:1'b1, rd:1'b0, addr:32'h1234_567C,
               wbeats:{64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888},
               rbeats:'0, exp_rdata:'0, exp_addr:32'h1234_5660, stall:0};
    tbl[4] = '{wr:1'b0, rd:1'b1, addr:32'h0000_0080, wbeats:'0,
               rbeats:{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0},
               exp_rdata:256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0,
               exp_addr:32'h0000_0080, stall:0};
    tbl[5] = '{wr:1'b1, rd:1'b1, addr:32'h0000_4010,
               wbeats:{64'h1, 64'h2, 64'h3, 64'h4},
               rbeats:{64'h9, 64'h9, 64'h9, 64'h9}, exp_rdata:'0, exp_addr:32'h0000_4000, stall:-1};

    rst = 1'b1;
    cacheline_read = 1'b0; cacheline_write = 1'b0;
    cacheline_address = '0; cacheline_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pmem_read",  256'(pmem_read), 256'(0));
    chk("reset pmem_write", 256'(pmem_write), 256'(0));
    chk("reset resp",       256'(cacheline_resp), 256'(0));
    chk("reset pmem_address", 256'(pmem_address), 256'(0));
    chk("reset rdata",      cacheline_rdata, 256'(0));
    chk("reset pmem_wdata", 256'(pmem_wdata), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table; consecutive entries are separated by the minimum idle gap.
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wbeats, tbl[i].rbeats,
              tbl[i].exp_rdata, tbl[i].exp_addr, tbl[i].stall, $sformatf("tbl%0d", i));

    // Reset after two beats of a fill: burst aborts, no completion pulse.
    cacheline_read = 1'b1; cacheline_address = 32'h0000_3000; pmem_resp = 1'b0;
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    chk("rstseq beat0 pmem_read", 256'(pmem_read), 256'(1));
    @(posedge clk); #1;
    pmem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk);
    chk("rstseq beat1 pmem_read", 256'(pmem_read), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1; pmem_resp = 1'b0;
    @(negedge clk);
    chk("rstseq pre-edge pmem_read", 256'(pmem_read), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0; cacheline_read = 1'b0;
    rd_tally = 0; wr_tally = 0; stall_tally = 0;
    @(negedge clk);
    chk("rstseq pmem_read", 256'(pmem_read), 256'(0));
    chk("rstseq resp",      256'(cacheline_resp), 256'(0));
    chk("rstseq rdata",     cacheline_rdata, 256'(0));
    chk("rstseq pmem_address", 256'(pmem_address), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstseq idle resp", 256'(cacheline_resp), 256'(0));
    chk("rstseq idle pmem_read", 256'(pmem_read), 256'(0));
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 32'h0000_3000, '0,
            {64'h4040404040404040, 64'h3030303030303030, 64'h2020202020202020, 64'h1010101010101010},
            256'h4040404040404040_3030303030303030_2020202020202020_1010101010101010,
            32'h0000_3000, -1, "post_reset_read");

    // Randomized transfers against the transaction-level model.
    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom % 3);
      wr  = (sel != 0);
      rd  = (sel != 1);
      a   = $urandom;
      q.delete();
      for (int b = 0; b < 4; b++) q.push_back({$urandom, $urandom});
      rb  = {q[3], q[2], q[1], q[0]};
      wb  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(wr, rd, a, wb, rb, {q[3], q[2], q[1], q[0]}, a - (a % 32),
              ($urandom % 2) ? -1 : int'($urandom_range(3, 0)), $sformatf("rand%0d", n));
    end

`ifdef L2_ADAPTOR_PERF_EN
    chk("perf rd_burst_count",    256'(dut.rd_burst_count),    256'(rd_tally));
    chk("perf wr_burst_count",    256'(dut.wr_burst_count),    256'(wr_tally));
    chk("perf stall_cycle_count", 256'(dut.stall_cycle_count), 256'(stall_tally));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Memory-side responder for the L2 cache controller's line interface (cacheline_read / cacheline_write / cacheline_resp).
- Accepts one full 256-bit line transfer request and converts it into a burst of 64-bit beats on the physical-memory port.
- Returns the completion handshake and the assembled line to the L2.
- Sits between the L2 datapath/control and the main-memory (pmem) model/arbiter.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, pmem beat width in bits; LINE_W must be an integer multiple of it.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cacheline_read  in  1  L2 requests a line fill; held until cacheline_resp.
- cacheline_write  in  1  L2 requests a line write-back; held until cacheline_resp.
- cacheline_address  in  ADDR_W  byte address of the line.
- cacheline_wdata  in  LINE_W  line to write back.
- cacheline_rdata  out  LINE_W  assembled fill line; valid while cacheline_resp=1.
- cacheline_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  ADDR_W  line-aligned burst address.
- pmem_wdata  out  BURST_W  current write beat.
- pmem_rdata  in  BURST_W  current read beat.
- pmem_resp  in  1  one beat accepted/delivered this cycle.

Behaviour:
- Derived constants: BEATS = LINE_W/BURST_W (default 4); OFFSET = log2(LINE_W/8) (default 5).
- Reset values: all outputs 0, state IDLE, beat counter 0, line buffer 0.
- A reset asserted mid-burst aborts at the next edge; pmem_read/pmem_write drop to 0 and no cacheline_resp is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - cacheline_write=1 -> latch address and wdata, go to WR_BURST.
  - else cacheline_read=1 -> latch address, go to RD_BURST.
  - Write has priority when both requests are high; the read is ignored, not queued.
- pmem_address = latched address with its low OFFSET bits forced to 0, held constant for the whole burst.
- RD_BURST:
  - pmem_read=1.
  - Each cycle with pmem_resp=1 stores pmem_rdata into beat slot [cnt*BURST_W +: BURST_W] and increments cnt.
  - Beat 0 is the lowest-addressed 64 bits.
  - On the beat where cnt==BEATS-1: go to DONE and clear cnt; pmem_read drops on the following cycle.
- WR_BURST:
  - pmem_write=1; pmem_wdata = latched slot cnt.
  - Each pmem_resp increments cnt; on the last beat go to DONE and clear cnt.
- pmem_resp may be low for any number of cycles between beats (stall); the adaptor holds its request, address and data unchanged.
- DONE:
  - cacheline_resp=1 for exactly one cycle.
  - For reads, cacheline_rdata holds the full line; the buffer is retained until the next fill's first beat.
  - Next state IDLE.
- Latency with no stalls: request seen in IDLE at cycle 0; beats at cycles 1..BEATS; resp at cycle BEATS+1.
- The minimum gap between completions is 1 IDLE cycle. This absorbs the L2's request deassertion following its own state change.
- A request dropped mid-burst does not abort the burst: the burst completes and resp still pulses; the L2 is required to hold the request.
- pmem_resp while idle or in DONE is ignored.
- cnt is $clog2(BEATS) bits wide and wraps only through the explicit clear.

Optional Feature:
- Macro L2_ADAPTOR_PERF_EN.
- When defined: internal 32-bit counters rd_burst_count, wr_burst_count and stall_cycle_count.
  - rd_burst_count / wr_burst_count increment on entry to DONE from the respective burst state.
  - stall_cycle_count increments on each burst-state cycle with pmem_resp=0.
  - All three are zeroed by rst and are readable hierarchically by the bench.
- When undefined: the counters are absent; ports and timing are identical.

Decomposition:
- Package l2_adaptor_pkg holds:
  - the state enum (IDLE, RD_BURST, WR_BURST, DONE);
  - default LINE_W, BURST_W, ADDR_W;
  - the derived BEATS and OFFSET constants.
- Single module; no sub-module is natural. The beat buffer and counter are small enough to remain inline.

Test Plan:
- Read, no stalls: cacheline_read=1, address 0x0000_1040; pmem returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles -> pmem_address=0x0000_1040, resp at cycle 5, rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with stalls: cacheline_write=1, wdata beats A/B/C/D, pmem_resp asserted only every 3rd cycle -> pmem_wdata steps A,B,C,D exactly on resp edges, pmem_write held throughout, one resp pulse at the end.
- Alignment: address 0x1234_567C -> pmem_address=0x1234_5660 for every beat.
- Write-back then fill: write completes, 1 idle cycle, read issued -> second burst starts with correct address, rdata unaffected by stale write data.
- Both requests high: read and write asserted together -> write burst performed, pmem_read never asserted.
- Reset mid-read after 2 beats -> next cycle pmem_read=0, no resp; a fresh read afterwards completes with all 4 beats correctly placed.
